// File: rtl/io_bridge_pkg.sv
// ---------------------------------------------------------------------------
// io_bridge_pkg
//   Shared definitions for the console register bridge:
//   - default register indices for the counter, status and halt registers
//   - bit positions inside the STATUS register
//   - register-select and halt-state enumerations
//   - clog2 and count-saturation helpers
// ---------------------------------------------------------------------------
package io_bridge_pkg;

  localparam int DEFAULT_CHAN_BASE     = 0;
  localparam int DEFAULT_COUNTER_INDEX = 4093;
  localparam int DEFAULT_STATUS_INDEX  = 4094;
  localparam int DEFAULT_HALT_INDEX    = 4095;

  // STATUS = {count[7:0], 4'b0, halt_pending, overflow, full, empty}
  localparam int STATUS_EMPTY_BIT        = 0;
  localparam int STATUS_FULL_BIT         = 1;
  localparam int STATUS_OVERFLOW_BIT     = 2;
  localparam int STATUS_HALT_PENDING_BIT = 3;
  localparam int STATUS_COUNT_LSB        = 8;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_CHAN    = 3'd1,
    SEL_COUNTER = 3'd2,
    SEL_STATUS  = 3'd3,
    SEL_HALT    = 3'd4
  } reg_sel_e;

  typedef enum logic [1:0] {
    HALT_RUN     = 2'd0,
    HALT_PENDING = 2'd1,
    HALT_DONE    = 2'd2
  } halt_state_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // FIFO occupancy as reported in STATUS saturates at 255.
  function automatic logic [7:0] sat_count8(input logic [31:0] count);
    if (count > 32'd255) begin
      return 8'hFF;
    end else begin
      return count[7:0];
    end
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// ---------------------------------------------------------------------------
// io_sync_fifo
//   Single-clock FIFO with read/write pointers carrying one extra wrap bit.
//   The head entry is held in a register, so a pushed word appears on
//   'head' one cycle after the push at the earliest (no bypass path).
//   A push while full and a pop while empty are ignored; fullness and
//   emptiness are those at the start of the cycle.
// Ports
//   clk, reset   clock, synchronous active-high reset
//   push, wdata  enqueue request and data
//   pop          dequeue request (takes effect only when not empty)
//   head         registered oldest entry (zero while empty)
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module io_sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] head_r;

  logic             push_ok_s;
  logic             pop_ok_s;
  logic [AW:0]      rd_ptr_next_s;
  logic [AW:0]      count_after_pop_s;
  logic [WIDTH-1:0] head_next_s;

  assign count = wr_ptr_r - rd_ptr_r;
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign head  = head_r;

  // Accepted operations and the head value after this edge.
  always_comb begin
    push_ok_s         = push && !full;
    pop_ok_s          = pop && !empty;
    rd_ptr_next_s     = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};
    count_after_pop_s = count - {{AW{1'b0}}, pop_ok_s};
    // When nothing older remains, the word being pushed becomes the new head.
    if (push_ok_s && (count_after_pop_s == {(AW+1){1'b0}})) begin
      head_next_s = wdata;
    end else if (count_after_pop_s == {(AW+1){1'b0}}) begin
      head_next_s = {WIDTH{1'b0}};
    end else begin
      head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Pointers and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, push_ok_s};
      rd_ptr_r <= rd_ptr_next_s;
      head_r   <= head_next_s;
    end
  end

endmodule

// File: rtl/io_console_bridge.sv
// ---------------------------------------------------------------------------
// io_console_bridge
//   Register-port peripheral for the ulisp core. Console bytes written to
//   channel registers are queued in one shared FIFO and drained over a
//   valid/ready byte stream. Also provides a status register, a free-running
//   cycle counter and a halt register that completes once the FIFO drains.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   register_index        12-bit register address
//   register_read/write   read and write strobes (independent, may coincide)
//   register_write_value  16-bit write data (channels use bits [7:0])
//   register_read_value   registered read data, 1-cycle latency, held
//   tx_valid/ready        byte stream handshake
//   tx_data, tx_channel   FIFO head byte and its source channel
//   halted                sticky halt flag
// ---------------------------------------------------------------------------
module io_console_bridge
  import io_bridge_pkg::*;
#(
  parameter int NUM_CHANNELS  = 1,
  parameter int FIFO_DEPTH    = 16,
  parameter int CHAN_BASE     = DEFAULT_CHAN_BASE,
  parameter int COUNTER_INDEX = DEFAULT_COUNTER_INDEX,
  parameter int STATUS_INDEX  = DEFAULT_STATUS_INDEX,
  parameter int HALT_INDEX    = DEFAULT_HALT_INDEX,
  localparam int CW = (clog2(NUM_CHANNELS) > 1) ? clog2(NUM_CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   register_index,
  input  logic          register_read,
  input  logic          register_write,
  input  logic [15:0]   register_write_value,
  output logic [15:0]   register_read_value,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic [CW-1:0] tx_channel,
  output logic          halted
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int EW = CW + 8;

  localparam logic [11:0] HALT_IDX    = 12'(HALT_INDEX);
  localparam logic [11:0] STATUS_IDX  = 12'(STATUS_INDEX);
  localparam logic [11:0] COUNTER_IDX = 12'(COUNTER_INDEX);
  localparam logic [31:0] CHAN_LO     = 32'(CHAN_BASE);
  localparam logic [31:0] CHAN_NUM    = 32'(NUM_CHANNELS);

  reg_sel_e      sel_s;
  logic [31:0]   chan_off_s;
  logic [CW-1:0] chan_s;
  logic          chan_write_s;
  logic          status_write_s;
  logic          counter_write_s;
  logic          halt_write_s;

  logic [EW-1:0] fifo_head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [AW:0]   fifo_count_s;

  logic          overflow_r;
  logic [15:0]   counter_r;
  logic [15:0]   read_value_r;
  halt_state_e   halt_state_r;
  logic          halted_r;
  logic          halt_pending_s;
  logic [15:0]   status_s;
  logic [15:0]   read_mux_s;

  logic          unused_s;
  assign unused_s = ^{register_write_value[15:8], chan_off_s[31:CW]};

  // Index decode with fixed priority HALT > STATUS > COUNTER > channel.
  // The channel offset wraps for indices below CHAN_BASE, so one unsigned
  // compare against NUM_CHANNELS covers both range bounds.
  always_comb begin
    chan_off_s = {20'h00000, register_index} - CHAN_LO;
    chan_s     = chan_off_s[CW-1:0];
    if (register_index == HALT_IDX) begin
      sel_s = SEL_HALT;
    end else if (register_index == STATUS_IDX) begin
      sel_s = SEL_STATUS;
    end else if (register_index == COUNTER_IDX) begin
      sel_s = SEL_COUNTER;
    end else if (chan_off_s < CHAN_NUM) begin
      sel_s = SEL_CHAN;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  assign chan_write_s    = register_write && (sel_s == SEL_CHAN);
  assign status_write_s  = register_write && (sel_s == SEL_STATUS);
  assign counter_write_s = register_write && (sel_s == SEL_COUNTER);
  assign halt_write_s    = register_write && (sel_s == SEL_HALT);

  io_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (chan_write_s),
    .wdata ({chan_s, register_write_value[7:0]}),
    .pop   (tx_ready),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign tx_valid            = !fifo_empty_s;
  assign tx_data             = fifo_head_s[7:0];
  assign tx_channel          = fifo_head_s[EW-1:8];
  assign halted              = halted_r;
  assign register_read_value = read_value_r;
  assign halt_pending_s      = (halt_state_r != HALT_RUN);

  // Sticky overflow: a channel write that finds the FIFO full is dropped,
  // even if a pop frees an entry on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (status_write_s) begin
      overflow_r <= 1'b0;
    end else if (chan_write_s && fifo_full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Cycle counter: a write loads zero and takes precedence over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_r <= 16'h0000;
    end else if (counter_write_s) begin
      counter_r <= 16'h0000;
    end else if (!halted_r) begin
      counter_r <= counter_r + 16'h0001;
    end
  end

  // Halt sequencing: request, then wait for the FIFO to drain before halting.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_state_r <= HALT_RUN;
      halted_r     <= 1'b0;
    end else begin
      case (halt_state_r)
        HALT_RUN: begin
          if (halt_write_s) begin
            halt_state_r <= HALT_PENDING;
          end
        end
        HALT_PENDING: begin
          if (fifo_empty_s) begin
            halt_state_r <= HALT_DONE;
            halted_r     <= 1'b1;
          end
        end
        HALT_DONE: begin
          halted_r <= 1'b1;
        end
        default: begin
          halt_state_r <= HALT_RUN;
          halted_r     <= 1'b0;
        end
      endcase
    end
  end

  // Status word assembly and read source selection.
  always_comb begin
    status_s = 16'h0000;
    status_s[STATUS_COUNT_LSB +: 8]   = sat_count8(32'(fifo_count_s));
    status_s[STATUS_HALT_PENDING_BIT] = halt_pending_s;
    status_s[STATUS_OVERFLOW_BIT]     = overflow_r;
    status_s[STATUS_FULL_BIT]         = fifo_full_s;
    status_s[STATUS_EMPTY_BIT]        = fifo_empty_s;
    case (sel_s)
      SEL_STATUS:  read_mux_s = status_s;
      SEL_COUNTER: read_mux_s = counter_r;
      default:     read_mux_s = 16'h0000;
    endcase
  end

  // Read data register: loads on a read strobe, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_value_r <= 16'h0000;
    end else if (register_read) begin
      read_value_r <= read_mux_s;
    end
  end

endmodule

// File: tb/tb_io_console_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_console_bridge
//   Two bridge instances: dut_a with default parameters (1 channel, depth 16)
//   and dut_b with 4 channels and depth 4. A vector table exercises queueing,
//   overflow, status and drain on dut_b; short hand-written sequences cover
//   the byte stream, halt, counter and reset corner cases.
// ---------------------------------------------------------------------------
module tb_io_console_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_rd, a_wr, a_txr;
  logic [11:0] a_idx;
  logic [15:0] a_wd, a_rv;
  logic        a_tv, a_halt;
  logic [7:0]  a_td;
  logic [0:0]  a_tc;

  logic        b_reset, b_rd, b_wr, b_txr;
  logic [11:0] b_idx;
  logic [15:0] b_wd, b_rv;
  logic        b_tv, b_halt;
  logic [7:0]  b_td;
  logic [1:0]  b_tc;

  io_console_bridge dut_a (
    .clk(clk), .reset(a_reset), .register_index(a_idx), .register_read(a_rd),
    .register_write(a_wr), .register_write_value(a_wd), .register_read_value(a_rv),
    .tx_valid(a_tv), .tx_ready(a_txr), .tx_data(a_td), .tx_channel(a_tc), .halted(a_halt)
  );

  io_console_bridge #(.NUM_CHANNELS(4), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(b_reset), .register_index(b_idx), .register_read(b_rd),
    .register_write(b_wr), .register_write_value(b_wd), .register_read_value(b_rv),
    .tx_valid(b_tv), .tx_ready(b_txr), .tx_data(b_td), .tx_channel(b_tc), .halted(b_halt)
  );

  localparam logic [11:0] IDX_COUNTER = 12'hFFD;
  localparam logic [11:0] IDX_STATUS  = 12'hFFE;
  localparam logic [11:0] IDX_HALT    = 12'hFFF;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle on dut_a; outputs are sampled 1 time unit after the edge.
  task automatic a_op(input logic wr, input logic rd, input logic [11:0] idx,
                      input logic [15:0] wd, input logic txr);
    a_wr = wr; a_rd = rd; a_idx = idx; a_wd = wd; a_txr = txr;
    @(posedge clk);
    #1;
    a_wr = 1'b0; a_rd = 1'b0; a_idx = 12'h000; a_wd = 16'h0000; a_txr = 1'b0;
  endtask

  task automatic b_op(input logic wr, input logic rd, input logic [11:0] idx,
                      input logic [15:0] wd, input logic txr);
    b_wr = wr; b_rd = rd; b_idx = idx; b_wd = wd; b_txr = txr;
    @(posedge clk);
    #1;
    b_wr = 1'b0; b_rd = 1'b0; b_idx = 12'h000; b_wd = 16'h0000; b_txr = 1'b0;
  endtask

  task automatic b_do_reset();
    b_reset = 1'b1;
    b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    b_reset = 1'b0;
  endtask

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [11:0] idx;
    logic [15:0] wd;
    logic        txr;
    logic        ev;   // expected tx_valid
    logic [7:0]  ed;   // expected tx_data (checked when ev)
    logic [1:0]  ech;  // expected tx_channel (checked when ev)
    logic        cr;   // check register_read_value
    logic [15:0] erd;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  initial begin
    //            wr    rd    idx      wd       txr   ev    ed     ech   cr    erd
    vecs[0]  = '{1'b1, 1'b0, 12'h000, 16'h0041, 1'b0, 1'b1, 8'h41, 2'd0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 12'h001, 16'h0042, 1'b0, 1'b1, 8'h41, 2'd0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 12'h002, 16'h0043, 1'b0, 1'b1, 8'h41, 2'd0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 12'h003, 16'h0044, 1'b0, 1'b1, 8'h41, 2'd0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 12'h000, 16'h0045, 1'b0, 1'b1, 8'h41, 2'd0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b1, 8'h41, 2'd0, 1'b1, 16'h0406};
    vecs[6]  = '{1'b1, 1'b0, IDX_STATUS, 16'h1234, 1'b0, 1'b1, 8'h41, 2'd0, 1'b1, 16'h0406};
    vecs[7]  = '{1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b1, 8'h41, 2'd0, 1'b1, 16'h0402};
    vecs[8]  = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 8'h42, 2'd1, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 8'h43, 2'd2, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 8'h44, 2'd3, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'h0001};
    vecs[13] = '{1'b1, 1'b0, 12'h000, 16'h0050, 1'b0, 1'b1, 8'h50, 2'd0, 1'b0, 16'h0000};
    vecs[14] = '{1'b1, 1'b0, 12'h001, 16'h0051, 1'b0, 1'b1, 8'h50, 2'd0, 1'b0, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 12'h002, 16'h0052, 1'b0, 1'b1, 8'h50, 2'd0, 1'b0, 16'h0000};
    vecs[16] = '{1'b1, 1'b0, 12'h003, 16'h0053, 1'b0, 1'b1, 8'h50, 2'd0, 1'b0, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 12'h000, 16'h0054, 1'b1, 1'b1, 8'h51, 2'd1, 1'b0, 16'h0000};
    vecs[18] = '{1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b1, 8'h51, 2'd1, 1'b1, 16'h0304};
    vecs[19] = '{1'b1, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b1, 8'h51, 2'd1, 1'b1, 16'h0304};
    vecs[20] = '{1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b1, 8'h51, 2'd1, 1'b1, 16'h0300};
    vecs[21] = '{1'b1, 1'b0, 12'h123, 16'h00AA, 1'b0, 1'b1, 8'h51, 2'd1, 1'b1, 16'h0300};
    vecs[22] = '{1'b0, 1'b1, 12'h001, 16'h0000, 1'b0, 1'b1, 8'h51, 2'd1, 1'b1, 16'h0000};
    vecs[23] = '{1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0, 1'b1, 8'h51, 2'd1, 1'b1, 16'h0300};
    vecs[24] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 8'h52, 2'd2, 1'b0, 16'h0000};
    vecs[25] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 8'h53, 2'd3, 1'b0, 16'h0000};
    vecs[26] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 16'h0000};

    a_wr = 1'b0; a_rd = 1'b0; a_idx = 12'h000; a_wd = 16'h0000; a_txr = 1'b0;
    b_wr = 1'b0; b_rd = 1'b0; b_idx = 12'h000; b_wd = 16'h0000; b_txr = 1'b0;

    // Reset state of both instances
    a_reset = 1'b1;
    b_reset = 1'b1;
    @(posedge clk);
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;
    check("a_rst_valid", a_tv, 1'b0);
    check("a_rst_data", a_td, 8'h00);
    check("a_rst_chan", a_tc, 1'b0);
    check("a_rst_rdval", a_rv, 16'h0000);
    check("a_rst_halted", a_halt, 1'b0);
    check("b_rst_valid", b_tv, 1'b0);
    check("b_rst_data", b_td, 8'h00);
    check("b_rst_chan", b_tc, 2'd0);
    check("b_rst_rdval", b_rv, 16'h0000);
    check("b_rst_halted", b_halt, 1'b0);

    // 'H' then 'i' on consecutive handshakes, then empty
    a_op(1'b1, 1'b0, 12'h000, 16'h0048, 1'b1);
    check("hi_v1", a_tv, 1'b1);
    check("hi_d1", a_td, 8'h48);
    check("hi_c1", a_tc, 1'b0);
    a_op(1'b1, 1'b0, 12'h000, 16'h0069, 1'b1);
    check("hi_v2", a_tv, 1'b1);
    check("hi_d2", a_td, 8'h69);
    a_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);
    check("hi_empty", a_tv, 1'b0);

    // Table-driven queue / overflow / status / drain on dut_b
    for (int i = 0; i < NVEC; i++) begin
      b_op(vecs[i].wr, vecs[i].rd, vecs[i].idx, vecs[i].wd, vecs[i].txr);
      check($sformatf("vec%0d_valid", i), b_tv, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_data", i), b_td, vecs[i].ed);
        check($sformatf("vec%0d_chan", i), b_tc, vecs[i].ech);
      end
      if (vecs[i].cr) begin
        check($sformatf("vec%0d_rdval", i), b_rv, vecs[i].erd);
      end
    end

    // Halt waits for the FIFO to drain, then freezes the counter
    b_do_reset();
    b_op(1'b1, 1'b0, IDX_COUNTER, 16'h0000, 1'b0);   // counter = 0
    b_op(1'b1, 1'b0, 12'h000, 16'h0061, 1'b0);       // 1
    b_op(1'b1, 1'b0, 12'h001, 16'h0062, 1'b0);       // 2
    b_op(1'b1, 1'b0, 12'h002, 16'h0063, 1'b0);       // 3
    b_op(1'b1, 1'b0, IDX_HALT, 16'h0000, 1'b0);      // 4
    check("halt_wait0", b_halt, 1'b0);
    b_op(1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0);    // 5
    check("halt_status", b_rv, 16'h0308);
    check("halt_wait1", b_halt, 1'b0);
    b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);       // 6, pop 0x61
    check("halt_pop1_d", b_td, 8'h62);
    check("halt_pop1_c", b_tc, 2'd1);
    b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);       // 7, pop 0x62
    check("halt_pop2_d", b_td, 8'h63);
    b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);       // 8, pop 0x63
    check("halt_pop3_empty", b_tv, 1'b0);
    check("halt_wait2", b_halt, 1'b0);
    b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);       // 9, halted rises
    check("halt_rise", b_halt, 1'b1);
    b_op(1'b0, 1'b1, IDX_COUNTER, 16'h0000, 1'b0);
    check("halt_counter_a", b_rv, 16'h0009);
    repeat (5) b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    b_op(1'b0, 1'b1, IDX_COUNTER, 16'h0000, 1'b0);
    check("halt_counter_b", b_rv, 16'h0009);
    b_op(1'b1, 1'b0, 12'h000, 16'h0077, 1'b0);
    check("halt_late_wr_v", b_tv, 1'b1);
    check("halt_late_wr_d", b_td, 8'h77);
    b_op(1'b1, 1'b0, IDX_COUNTER, 16'h0000, 1'b0);
    b_op(1'b0, 1'b1, IDX_COUNTER, 16'h0000, 1'b0);
    check("halt_counter_load", b_rv, 16'h0000);
    check("halt_sticky", b_halt, 1'b1);

    // Reset with bytes queued and a halt pending
    b_do_reset();
    b_op(1'b1, 1'b0, 12'h000, 16'h0031, 1'b0);
    b_op(1'b1, 1'b0, 12'h001, 16'h0032, 1'b0);
    b_op(1'b1, 1'b0, IDX_HALT, 16'h0000, 1'b0);
    b_op(1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0);
    check("rst_pre_status", b_rv, 16'h0208);
    b_do_reset();
    check("rst_mid_valid", b_tv, 1'b0);
    check("rst_mid_halted", b_halt, 1'b0);
    check("rst_mid_rdval", b_rv, 16'h0000);
    b_op(1'b0, 1'b1, IDX_STATUS, 16'h0000, 1'b0);
    check("rst_mid_status", b_rv, 16'h0001);
    b_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    check("rst_no_halt", b_halt, 1'b0);

    // Counter write at cycle t, read strobe at t+10
    a_op(1'b1, 1'b0, IDX_COUNTER, 16'h0000, 1'b0);
    repeat (9) a_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    a_op(1'b0, 1'b1, IDX_COUNTER, 16'h0000, 1'b0);
    check("cnt_t10", a_rv, 16'h0009);

    // Counter wrap: 65535 edges after a load reach FFFF, the next wraps to 0
    a_op(1'b1, 1'b0, IDX_COUNTER, 16'h0000, 1'b0);
    repeat (65535) a_op(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    a_op(1'b0, 1'b1, IDX_COUNTER, 16'h0000, 1'b0);
    check("cnt_ffff", a_rv, 16'hFFFF);
    a_op(1'b0, 1'b1, IDX_COUNTER, 16'h0000, 1'b0);
    check("cnt_wrap", a_rv, 16'h0000);
    check("cnt_not_halted", a_halt, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
